// File: rtl/bus85_if.sv
// 8085 multiplexed bus as seen by a memory/IO slave.
// The core drives the strobes and the AD/high-address lines; the slave returns
// read data, the AD drive enable and READY.
interface bus85_if #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 16
);
    logic                         ale;
    logic                         iom_;
    logic                         rd_;
    logic                         wr_;
    logic [DATASIZE-1:0]          ad_in;
    logic [ADDRSIZE-DATASIZE-1:0] a_hi;
    logic [DATASIZE-1:0]          ad_out;
    logic                         ad_oe;
    logic                         ready;

    modport master (
        output ale, iom_, rd_, wr_, ad_in, a_hi,
        input  ad_out, ad_oe, ready
    );

    modport slave (
        input  ale, iom_, rd_, wr_, ad_in, a_hi,
        output ad_out, ad_oe, ready
    );
endinterface

// File: rtl/bus85_memory.sv
// Memory slave for the 8085 multiplexed bus: latches the address on ALE,
// serves RD_/WR_ cycles from a block-RAM array, stretches the cycle with
// programmable wait states, blocks writes to the low ROM window and counts
// completed accesses.
module bus85_memory #(
    parameter int   DATASIZE = 8,
    parameter int   ADDRSIZE = 16,
    parameter int   MEMBITS  = 12,
    parameter int   ROMSIZE  = 256,
    parameter logic IOM_SEL  = 1'b0,
    parameter int   WAITBITS = 4
) (
    input  logic                clk,
    input  logic                rst_,
    bus85_if.slave              bus,
    input  logic [WAITBITS-1:0] wait_n,
    input  logic                bd_we,
    input  logic [MEMBITS-1:0]  bd_addr,
    input  logic [DATASIZE-1:0] bd_data,
    output logic                wp_err,
    output logic [15:0]         acc_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_LATCHED, S_WAIT, S_XFER} state_t;

    state_t              state, state_nxt;
    logic [ADDRSIZE-1:0] addr;
    logic [MEMBITS-1:0]  idx;
    logic [WAITBITS-1:0] cnt;
    logic                is_rd;
    logic [DATASIZE-1:0] wdat;
    logic [DATASIZE-1:0] mem [2**MEMBITS];

    // control strobes from the FSM to the datapath
    logic space_ok;
    logic protect;
    logic latch;
    logic dir_load;
    logic cnt_load;
    logic rd_load;
    logic oe_clr;
    logic rdy_lo;
    logic rdy_hi;
    logic bus_we;
    logic wp_set;
    logic cnt_inc;

    // upper address bits alias onto the array; protection uses the full address
    assign idx      = addr[MEMBITS-1:0];
    assign space_ok = (bus.iom_ == IOM_SEL);
    assign protect  = (addr < ADDRSIZE'(ROMSIZE));

    // state register
    always_ff @(posedge clk) begin
        if (!rst_) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // next state and datapath strobes; ALE outside IDLE always aborts first
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        dir_load  = 1'b0;
        cnt_load  = 1'b0;
        rd_load   = 1'b0;
        oe_clr    = 1'b0;
        rdy_lo    = 1'b0;
        rdy_hi    = 1'b0;
        bus_we    = 1'b0;
        wp_set    = 1'b0;
        cnt_inc   = 1'b0;
        if (state != S_IDLE && bus.ale) begin
            oe_clr = 1'b1;
            rdy_hi = 1'b1;
            if (space_ok) begin
                latch     = 1'b1;
                state_nxt = S_LATCHED;
            end else begin
                state_nxt = S_IDLE;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ale && space_ok) begin
                        latch     = 1'b1;
                        state_nxt = S_LATCHED;
                    end
                end
                S_LATCHED: begin
                    if (!bus.rd_ && !bus.wr_) begin
                        state_nxt = S_IDLE;
                    end else if (!bus.rd_ || !bus.wr_) begin
                        dir_load = 1'b1;
                        if (wait_n == '0) begin
                            rd_load   = !bus.rd_;
                            state_nxt = S_XFER;
                        end else begin
                            cnt_load  = 1'b1;
                            rdy_lo    = 1'b1;
                            state_nxt = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == WAITBITS'(1)) begin
                        rdy_hi    = 1'b1;
                        rd_load   = is_rd;
                        state_nxt = S_XFER;
                    end
                end
                S_XFER: begin
                    if (is_rd) begin
                        if (bus.rd_) begin
                            oe_clr    = 1'b1;
                            cnt_inc   = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end else if (bus.wr_) begin
                        cnt_inc   = 1'b1;
                        wp_set    = protect;
                        bus_we    = !protect;
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // datapath registers and bus-facing outputs
    always_ff @(posedge clk) begin
        if (!rst_) begin
            addr       <= '0;
            cnt        <= '0;
            is_rd      <= 1'b0;
            wdat       <= '0;
            bus.ad_out <= '0;
            bus.ad_oe  <= 1'b0;
            bus.ready  <= 1'b1;
            wp_err     <= 1'b0;
            acc_cnt    <= '0;
        end else begin
            wp_err <= wp_set;
            if (latch)    addr  <= {bus.a_hi, bus.ad_in};
            if (dir_load) is_rd <= !bus.rd_;
            if (cnt_load)            cnt <= wait_n;
            else if (state == S_WAIT) cnt <= cnt - WAITBITS'(1);
            // write data is only guaranteed while WR_ is low, so track it then
            if (state != S_IDLE && !bus.wr_) wdat <= bus.ad_in;
            if (rd_load) begin
                bus.ad_out <= mem[idx];
                bus.ad_oe  <= 1'b1;
            end else if (oe_clr) begin
                bus.ad_oe  <= 1'b0;
            end
            if (rdy_lo)      bus.ready <= 1'b0;
            else if (rdy_hi) bus.ready <= 1'b1;
            if (cnt_inc && acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
        end
    end

    // array writes; the bus write is last so it wins a same-word collision
    always_ff @(posedge clk) begin
        if (bd_we)          mem[bd_addr] <= bd_data;
        if (bus_we && rst_) mem[idx]     <= wdat;
    end

endmodule

// File: tb/tb_bus85_memory.sv
// Directed bench for bus85_memory: core-style bus cycles with hand-computed
// expectations; read data is checked by a scoreboard monitor on ad_oe rise.
module tb_bus85_memory;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int MB = 12;
    localparam int WB = 4;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    bus85_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

    logic [WB-1:0] wait_n = '0;
    logic          bd_we = 1'b0;
    logic [MB-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;
    logic          wp_err;
    logic [15:0]   acc_cnt;

    bus85_memory #(
        .DATASIZE(DW), .ADDRSIZE(AW), .MEMBITS(MB), .ROMSIZE(256),
        .IOM_SEL(1'b0), .WAITBITS(WB)
    ) dut (
        .clk(clk), .rst_(rst_), .bus(bus), .wait_n(wait_n),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data),
        .wp_err(wp_err), .acc_cnt(acc_cnt)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;
    logic          oe_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every new AD drive must match the oldest expected read
    always @(negedge clk) begin
        if (bus.ad_oe === 1'b1 && !oe_prev) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_drive: ad_out=%0h with no read expected", bus.ad_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.ad_out !== mon_exp) begin
                    n_fail++;
                    $display("FAIL read_data: got %0h expected %0h", bus.ad_out, mon_exp);
                end
            end
        end
        oe_prev = (bus.ad_oe === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [MB-1:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic addr_phase(input logic [15:0] a, input logic io);
        bus.ale = 1'b1; bus.iom_ = io; bus.a_hi = a[15:8]; bus.ad_in = a[7:0];
        tick();
        bus.ale = 1'b0;
    endtask

    // full read cycle; wait_n is scrambled once it is past LATCHED
    task automatic do_read(input string name, input logic [15:0] a,
                           input logic [DW-1:0] exp, input int nwait);
        int w;
        exp_q.push_back(exp);
        wait_n = nwait[WB-1:0];
        addr_phase(a, 1'b0);
        bus.ad_in = '0; bus.rd_ = 1'b0;
        tick();
        wait_n = 4'hF;
        w = 0;
        while (bus.ready !== 1'b1 && w < 32) begin w++; tick(); end
        check({name, "_waits"}, w, nwait);
        check({name, "_oe"}, {31'd0, bus.ad_oe}, 1);
        bus.rd_ = 1'b1;
        tick();
        check({name, "_oe_off"}, {31'd0, bus.ad_oe}, 0);
        wait_n = nwait[WB-1:0];
    endtask

    task automatic do_write(input string name, input logic [15:0] a, input logic [DW-1:0] d,
                            input int nwait, input logic exp_wp);
        int w;
        wait_n = nwait[WB-1:0];
        addr_phase(a, 1'b0);
        bus.ad_in = d; bus.wr_ = 1'b0;
        tick();
        wait_n = 4'hF;
        w = 0;
        while (bus.ready !== 1'b1 && w < 32) begin w++; tick(); end
        check({name, "_waits"}, w, nwait);
        bus.wr_ = 1'b1;
        tick();
        check({name, "_wp"}, {31'd0, wp_err}, {31'd0, exp_wp});
        bus.ad_in = '0;
        tick();
        check({name, "_wp_end"}, {31'd0, wp_err}, 0);
        wait_n = nwait[WB-1:0];
    endtask

    initial begin
        bus.ale = 1'b0; bus.iom_ = 1'b0; bus.rd_ = 1'b1; bus.wr_ = 1'b1;
        bus.ad_in = '0; bus.a_hi = '0;
        tick(); tick();
        check("rst_ready", {31'd0, bus.ready}, 1);
        check("rst_oe", {31'd0, bus.ad_oe}, 0);
        check("rst_ad_out", {24'd0, bus.ad_out}, 0);
        check("rst_wp", {31'd0, wp_err}, 0);
        check("rst_acc", {16'd0, acc_cnt}, 0);
        rst_ = 1'b1;
        bd_write(12'h000, 8'h3E);
        bd_write(12'h001, 8'h55);
        bd_write(12'h200, 8'hA5);
        bd_write(12'h010, 8'hC3);

        do_read("rd1", 16'h0001, 8'h55, 0);
        check("acc1", {16'd0, acc_cnt}, 1);
        do_read("rd0", 16'h0000, 8'h3E, 0);
        do_read("rd200_w3", 16'h0200, 8'hA5, 3);
        check("acc3", {16'd0, acc_cnt}, 3);

        do_write("wr300", 16'h0300, 8'h77, 0, 1'b0);
        do_read("rd300", 16'h0300, 8'h77, 0);
        do_write("wr_rom", 16'h0010, 8'h11, 2, 1'b1);
        do_read("rd_rom", 16'h0010, 8'hC3, 0);
        check("acc7", {16'd0, acc_cnt}, 7);

        do_write("wr_alias", 16'h1300, 8'h9C, 1, 1'b0);
        do_read("rd_alias", 16'h0300, 8'h9C, 0);
        check("acc9", {16'd0, acc_cnt}, 9);

        // IO-space cycle must be ignored
        addr_phase(16'h0300, 1'b1);
        bus.rd_ = 1'b0;
        tick(); tick();
        check("io_oe", {31'd0, bus.ad_oe}, 0);
        bus.rd_ = 1'b1; bus.iom_ = 1'b0;
        tick();
        check("io_acc", {16'd0, acc_cnt}, 9);

        // reset during the wait states of a write
        wait_n = 4'd4;
        addr_phase(16'h0300, 1'b0);
        bus.ad_in = 8'h44; bus.wr_ = 1'b0;
        tick();
        check("rstw_ready_lo", {31'd0, bus.ready}, 0);
        tick();
        rst_ = 1'b0;
        tick();
        check("rstw_ready", {31'd0, bus.ready}, 1);
        check("rstw_acc", {16'd0, acc_cnt}, 0);
        rst_ = 1'b1; bus.wr_ = 1'b1; bus.ad_in = '0;
        tick(); tick();
        do_read("rstw_rd", 16'h0300, 8'h9C, 0);
        check("rstw_acc1", {16'd0, acc_cnt}, 1);

        // ALE during read XFER aborts and re-latches
        wait_n = '0;
        exp_q.push_back(8'h3E);
        addr_phase(16'h0000, 1'b0);
        bus.rd_ = 1'b0;
        tick();
        check("abort_oe_on", {31'd0, bus.ad_oe}, 1);
        bus.ale = 1'b1; bus.a_hi = 8'h00; bus.ad_in = 8'h01; bus.rd_ = 1'b1;
        tick();
        check("abort_oe_off", {31'd0, bus.ad_oe}, 0);
        check("abort_acc", {16'd0, acc_cnt}, 1);
        exp_q.push_back(8'h55);
        bus.ale = 1'b0; bus.ad_in = '0; bus.rd_ = 1'b0;
        tick();
        check("abort_new_oe", {31'd0, bus.ad_oe}, 1);
        bus.rd_ = 1'b1;
        tick();
        check("abort_acc2", {16'd0, acc_cnt}, 2);

        // RD_ and WR_ low together: no drive, no write
        addr_phase(16'h0300, 1'b0);
        bus.rd_ = 1'b0; bus.wr_ = 1'b0; bus.ad_in = 8'hEE;
        tick();
        check("ill_oe", {31'd0, bus.ad_oe}, 0);
        tick();
        bus.rd_ = 1'b1; bus.wr_ = 1'b1; bus.ad_in = '0;
        tick();
        check("ill_acc", {16'd0, acc_cnt}, 2);
        do_read("ill_rd", 16'h0300, 8'h9C, 0);

        // saturation: preset the counter near the top, then keep reading
        @(negedge clk);
        force dut.acc_cnt = 16'hFFFD;
        #1;
        release dut.acc_cnt;
        do_read("sat_rd1", 16'h0001, 8'h55, 0);
        do_read("sat_rd2", 16'h0001, 8'h55, 0);
        check("sat_top", {16'd0, acc_cnt}, 32'hFFFF);
        do_read("sat_rd3", 16'h0001, 8'h55, 0);
        check("sat_hold", {16'd0, acc_cnt}, 32'hFFFF);

        tick();
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
